muldiv_sequencer: RTL

//  Iterative RV32M multiply/divide engine with its own sequencing FSM, beside the execute-stage ALU.

---
 rtl/muldiv_sequencer.sv | 119 +++++++++++
 1 files changed

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative RV32M multiply/divide engine that stalls the execute stage while it iterates
// Ports: clk/rst (async active-high); start_e/op_e/src1_e/src2_e capture an operation in IDLE;
// flush_e kills the in-flight operation; stall_e holds the pipeline; busy = not IDLE;
// result_valid pulses for one cycle alongside result_e.
module muldiv_sequencer #(
  parameter int WIDTH    = 32,
  parameter bit FAST_DIV = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_e,
  input  logic [2:0]       op_e,
  input  logic [WIDTH-1:0] src1_e,
  input  logic [WIDTH-1:0] src2_e,
  input  logic             flush_e,
  output logic             stall_e,
  output logic             busy,
  output logic             result_valid,
  output logic [WIDTH-1:0] result_e
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [1:0] S_IDLE = 2'd0, S_CALC = 2'd1, S_FIX = 2'd2, S_DONE = 2'd3;
  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2:0]         op_q, op_d;
  logic               s1_q, s1_d, s2_q, s2_d, zero_q, zero_d;
  logic [WIDTH-1:0]   opa_q, opa_d, result_q, result_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic               sgn1, sgn2, neg1, neg2, fast, ge;
  logic [WIDTH-1:0]   abs1, abs2, fast_res, diff, q_n, r_n, fix_res;
  logic [WIDTH:0]     mul_sum, shifted;
  logic [2*WIDTH-1:0] mul_next, div_next, prod_n;
  // MULHSU treats only rs1 as signed; MULHU/DIVU/REMU treat neither
  assign sgn1 = ~op_e[0] | (op_e == 3'd1);
  assign sgn2 = sgn1 & (op_e != 3'd2);
  assign neg1 = sgn1 & src1_e[WIDTH-1];
  assign neg2 = sgn2 & src2_e[WIDTH-1];
  assign abs1 = neg1 ? -src1_e : src1_e;
  assign abs2 = neg2 ? -src2_e : src2_e;
  assign fast = FAST_DIV && op_e[2] && ((src2_e == '0) ||
                (~op_e[0] && (src1_e == {1'b1, {(WIDTH-1){1'b0}}}) && (&src2_e)));
  assign fast_res = (src2_e == '0) ? (op_e[1] ? src1_e : '1) : (op_e[1] ? '0 : src1_e);
  // acc_q = {high, low}: product accumulator for MUL, {remainder, quotient} for DIV
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opa_q} : '0);
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};
  assign shifted  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign ge       = shifted >= {1'b0, opa_q};
  assign diff     = shifted[WIDTH-1:0] - opa_q;
  assign div_next = {ge ? diff : shifted[WIDTH-1:0], acc_q[WIDTH-2:0], ge};
  assign prod_n   = (s1_q ^ s2_q) ? -acc_q : acc_q;
  // a zero divisor yields an all-ones quotient regardless of the dividend sign
  assign q_n      = ((s1_q ^ s2_q) & ~zero_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign r_n      = s1_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  assign fix_res  = op_q[2] ? (op_q[1] ? r_n : q_n)
                            : ((op_q == 3'd0) ? prod_n[WIDTH-1:0] : prod_n[2*WIDTH-1:WIDTH]);
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    s1_d     = s1_q;
    s2_d     = s2_q;
    zero_d   = zero_q;
    opa_d    = opa_q;
    acc_d    = acc_q;
    result_d = result_q;
    if (state_q == S_IDLE) begin
      if (start_e && !flush_e) begin
        op_d     = op_e;
        s1_d     = neg1;
        s2_d     = neg2;
        zero_d   = (src2_e == '0);
        cnt_d    = CW'(WIDTH-1);
        opa_d    = op_e[2] ? abs2 : abs1;
        acc_d    = {{WIDTH{1'b0}}, op_e[2] ? abs1 : abs2};
        result_d = fast ? fast_res : result_q;
        state_d  = fast ? S_DONE : S_CALC;
      end
    end else if (flush_e) begin
      state_d = S_IDLE;
    end else if (state_q == S_CALC) begin
      acc_d   = op_q[2] ? div_next : mul_next;
      cnt_d   = cnt_q - 1'b1;
      state_d = (cnt_q == '0) ? S_FIX : S_CALC;
    end else if (state_q == S_FIX) begin
      result_d = fix_res;
      state_d  = S_DONE;
    end else begin
      state_d = S_IDLE;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      zero_q   <= 1'b0;
      opa_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      zero_q   <= zero_d;
      opa_q    <= opa_d;
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end
  assign stall_e      = ~flush_e & (((state_q == S_IDLE) & start_e & ~fast) |
                                    (state_q == S_CALC) | (state_q == S_FIX));
  assign busy         = state_q != S_IDLE;
  assign result_valid = (state_q == S_DONE) & ~flush_e;
  assign result_e     = result_q;
endmodule
